// File: rtl/target_hit_detect_pkg.sv
// rtl/target_hit_detect_pkg.sv - shared VGA constants and target types
// Purpose: 800x600 VGA extents, counter/colour widths, the bullet colour
//          (shared with the shot stage), target geometry/colours and the
//          target FSM state type.
// Ports:   none (package).
package target_hit_detect_pkg;

  localparam int H_ACTIVE = 800;
  localparam int V_ACTIVE = 600;
  localparam int CNT_W    = 11;
  localparam int RGB_W    = 12;
  localparam int WIDE_W   = CNT_W + 1;

  localparam logic [RGB_W-1:0] BULLET_RGB = 12'hf00;
  localparam logic [RGB_W-1:0] TARGET_RGB = 12'h0f0;
  localparam logic [RGB_W-1:0] FLASH_RGB  = 12'hfff;

  localparam int TARGET_SIZE  = 32;
  localparam int TARGET_Y     = 100;
  localparam int X_MIN        = 0;
  localparam int X_MAX        = H_ACTIVE - TARGET_SIZE - 1;
  localparam int TARGET_SPEED = 2;
  localparam int FLASH_FRAMES = 30;
  localparam int FLASH_W      = $clog2(FLASH_FRAMES);
  localparam int SCORE_W      = 8;

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_FLASH   = 2'd1,
    ST_RESPAWN = 2'd2
  } tgt_state_t;

  // Inclusive span test [lo, lo+len-1]; 12-bit operands so the upper bound never wraps.
  function automatic logic in_span(input logic [WIDE_W-1:0] val,
                                   input logic [WIDE_W-1:0] lo,
                                   input logic [WIDE_W-1:0] len);
    return (val >= lo) && (val <= lo + len - 12'd1);
  endfunction

endpackage

// File: rtl/target_motion.sv
// rtl/target_motion.sv - horizontal target position with edge bounce
// Purpose: holds the target's left x and direction; moves TARGET_SPEED per
//          step pulse, clamping and reversing at X_MIN / X_MAX.
// Ports:   i_clk      pixel clock
//          i_rst      synchronous active-high reset (tx=X_MIN, moving right)
//          i_step     advance one frame's worth of motion
//          i_respawn  return to X_MIN moving right (has priority over i_step)
//          o_tx       current target left x
module target_motion
  import target_hit_detect_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step,
  input  logic             i_respawn,
  output logic [CNT_W-1:0] o_tx
);

  logic [CNT_W-1:0]  r_tx;
  logic              r_dir_left;
  logic [CNT_W-1:0]  w_tx_next;
  logic              w_dir_left_next;
  logic [WIDE_W-1:0] w_tx_wide;
  logic [WIDE_W-1:0] w_sum;

  assign w_tx_wide = {1'b0, r_tx};
  assign w_sum     = w_tx_wide + WIDE_W'(TARGET_SPEED);

  always_comb begin
    w_tx_next       = r_tx;
    w_dir_left_next = r_dir_left;
    if (i_respawn) begin
      w_tx_next       = CNT_W'(X_MIN);
      w_dir_left_next = 1'b0;
    end else if (i_step) begin
      if (!r_dir_left) begin
        if (w_sum >= WIDE_W'(X_MAX)) begin
          w_tx_next       = CNT_W'(X_MAX);
          w_dir_left_next = 1'b1;
        end else begin
          w_tx_next = w_sum[CNT_W-1:0];
        end
      end else begin
        if (w_tx_wide < WIDE_W'(X_MIN + TARGET_SPEED)) begin
          w_tx_next       = CNT_W'(X_MIN);
          w_dir_left_next = 1'b0;
        end else begin
          w_tx_next = r_tx - CNT_W'(TARGET_SPEED);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx       <= CNT_W'(X_MIN);
      r_dir_left <= 1'b0;
    end else begin
      r_tx       <= w_tx_next;
      r_dir_left <= w_dir_left_next;
    end
  end

  assign o_tx = r_tx;

endmodule

// File: rtl/target_hit_detect.sv
// rtl/target_hit_detect.sv - moving target overlay, bullet hit detection and score
// Purpose: VGA stage after the shot stage. Draws a moving square target,
//          detects bullet-coloured pixels inside it, flashes the target after
//          a hit, then respawns it at the left edge. Keeps a saturating score.
// Ports:   i_clk, i_rst          pixel clock, synchronous active-high reset
//          i_hcount, i_vcount    pixel counters in
//          i_h_sync, i_v_sync    syncs in
//          i_h_blank, i_v_blank  blanking in
//          i_rgb                 pixel colour from shot stage
//          o_hcount .. o_v_blank video timing, delayed 2 clk
//          o_rgb                 colour with target overlay, delayed 2 clk
//          o_hit                 1-clk pulse at frame start after a hit frame
//          o_score               hit count, saturates at 255
module target_hit_detect
  import target_hit_detect_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [CNT_W-1:0]   i_hcount,
  input  logic [CNT_W-1:0]   i_vcount,
  input  logic               i_h_sync,
  input  logic               i_v_sync,
  input  logic               i_h_blank,
  input  logic               i_v_blank,
  input  logic [RGB_W-1:0]   i_rgb,
  output logic [CNT_W-1:0]   o_hcount,
  output logic [CNT_W-1:0]   o_vcount,
  output logic               o_h_sync,
  output logic               o_v_sync,
  output logic               o_h_blank,
  output logic               o_v_blank,
  output logic [RGB_W-1:0]   o_rgb,
  output logic               o_hit,
  output logic [SCORE_W-1:0] o_score
);

  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  // Stage 1: registered inputs
  logic [CNT_W-1:0]   r_s1_hcount;
  logic [CNT_W-1:0]   r_s1_vcount;
  logic               r_s1_h_sync;
  logic               r_s1_v_sync;
  logic               r_s1_h_blank;
  logic               r_s1_v_blank;
  logic [RGB_W-1:0]   r_s1_rgb;
  logic               r_frame_start;

  // Stage 2: output registers
  logic [CNT_W-1:0]   r_s2_hcount;
  logic [CNT_W-1:0]   r_s2_vcount;
  logic               r_s2_h_sync;
  logic               r_s2_v_sync;
  logic               r_s2_h_blank;
  logic               r_s2_v_blank;
  logic [RGB_W-1:0]   r_s2_rgb;

  tgt_state_t         r_state;
  tgt_state_t         w_state_next;
  logic [FLASH_W-1:0] r_flash_cnt;
  logic [FLASH_W-1:0] w_flash_cnt_next;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_next;
  logic               r_hit;
  logic               w_hit_next;
  logic               r_hit_seen;
  logic               w_step;
  logic               w_respawn;

  logic [CNT_W-1:0]   w_tx;
  logic               w_in_box;
  logic               w_active;
  logic               w_is_bullet;
  logic [RGB_W-1:0]   w_rgb_overlay;

  target_motion u_motion (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_step    (w_step),
    .i_respawn (w_respawn),
    .o_tx      (w_tx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_hcount   <= '0;
      r_s1_vcount   <= '0;
      r_s1_h_sync   <= 1'b0;
      r_s1_v_sync   <= 1'b0;
      r_s1_h_blank  <= 1'b0;
      r_s1_v_blank  <= 1'b0;
      r_s1_rgb      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_s1_hcount   <= i_hcount;
      r_s1_vcount   <= i_vcount;
      r_s1_h_sync   <= i_h_sync;
      r_s1_v_sync   <= i_v_sync;
      r_s1_h_blank  <= i_h_blank;
      r_s1_v_blank  <= i_v_blank;
      r_s1_rgb      <= i_rgb;
      r_frame_start <= (i_hcount == '0) && (i_vcount == '0);
    end
  end

  // Pixel classification on the stage-1 pixel against the current target position.
  assign w_in_box = in_span({1'b0, r_s1_hcount}, {1'b0, w_tx}, WIDE_W'(TARGET_SIZE)) &&
                    in_span({1'b0, r_s1_vcount}, WIDE_W'(TARGET_Y), WIDE_W'(TARGET_SIZE));
  assign w_active    = !r_s1_h_blank && !r_s1_v_blank;
  assign w_is_bullet = (r_s1_rgb == BULLET_RGB);

  // Bullets stay visible on top of the target so the player sees the impact.
  always_comb begin
    w_rgb_overlay = r_s1_rgb;
    if (w_in_box && w_active && !w_is_bullet) begin
      w_rgb_overlay = (r_state == ST_FLASH) ? FLASH_RGB : TARGET_RGB;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_hcount  <= '0;
      r_s2_vcount  <= '0;
      r_s2_h_sync  <= 1'b0;
      r_s2_v_sync  <= 1'b0;
      r_s2_h_blank <= 1'b0;
      r_s2_v_blank <= 1'b0;
      r_s2_rgb     <= '0;
    end else begin
      r_s2_hcount  <= r_s1_hcount;
      r_s2_vcount  <= r_s1_vcount;
      r_s2_h_sync  <= r_s1_h_sync;
      r_s2_v_sync  <= r_s1_v_sync;
      r_s2_h_blank <= r_s1_h_blank;
      r_s2_v_blank <= r_s1_v_blank;
      r_s2_rgb     <= w_rgb_overlay;
    end
  end

  // Sticky per-frame hit flag; the frame start clears it so the FSM sees
  // exactly the previous frame's verdict, and many bullet pixels count once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit_seen <= 1'b0;
    end else if (r_frame_start) begin
      r_hit_seen <= 1'b0;
    end else if ((r_state == ST_ACTIVE) && w_in_box && w_active && w_is_bullet) begin
      r_hit_seen <= 1'b1;
    end
  end

  // Target FSM: every transition is qualified by the frame start pulse.
  always_comb begin
    w_state_next     = r_state;
    w_flash_cnt_next = r_flash_cnt;
    w_score_next     = r_score;
    w_hit_next       = 1'b0;
    w_step           = 1'b0;
    w_respawn        = 1'b0;
    if (r_frame_start) begin
      case (r_state)
        ST_ACTIVE: begin
          // A hit takes priority over motion, so the target freezes where it was struck.
          if (r_hit_seen) begin
            w_state_next     = ST_FLASH;
            w_hit_next       = 1'b1;
            w_flash_cnt_next = FLASH_LOAD;
            w_score_next     = (r_score == SCORE_MAX) ? r_score : r_score + 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
        ST_FLASH: begin
          if (r_flash_cnt == '0) begin
            w_state_next = ST_RESPAWN;
          end else begin
            w_flash_cnt_next = r_flash_cnt - 1'b1;
          end
        end
        ST_RESPAWN: begin
          w_respawn    = 1'b1;
          w_state_next = ST_ACTIVE;
        end
        default: begin
          w_state_next = ST_ACTIVE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_ACTIVE;
      r_flash_cnt <= '0;
      r_score     <= '0;
      r_hit       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flash_cnt <= w_flash_cnt_next;
      r_score     <= w_score_next;
      r_hit       <= w_hit_next;
    end
  end

  assign o_hcount  = r_s2_hcount;
  assign o_vcount  = r_s2_vcount;
  assign o_h_sync  = r_s2_h_sync;
  assign o_v_sync  = r_s2_v_sync;
  assign o_h_blank = r_s2_h_blank;
  assign o_v_blank = r_s2_v_blank;
  assign o_rgb     = r_s2_rgb;
  assign o_hit     = r_hit;
  assign o_score   = r_score;

endmodule

// File: tb/tb_target_hit_detect.sv
// tb/tb_target_hit_detect.sv - self-checking bench for target_hit_detect
module tb_target_hit_detect;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [10:0] i_hcount = '0;
  logic [10:0] i_vcount = '0;
  logic        i_h_sync = 1'b0;
  logic        i_v_sync = 1'b0;
  logic        i_h_blank = 1'b0;
  logic        i_v_blank = 1'b0;
  logic [11:0] i_rgb = '0;
  logic [10:0] o_hcount;
  logic [10:0] o_vcount;
  logic        o_h_sync;
  logic        o_v_sync;
  logic        o_h_blank;
  logic        o_v_blank;
  logic [11:0] o_rgb;
  logic        o_hit;
  logic [7:0]  o_score;

  always #5 clk = ~clk;

  target_hit_detect dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_hcount  (i_hcount),
    .i_vcount  (i_vcount),
    .i_h_sync  (i_h_sync),
    .i_v_sync  (i_v_sync),
    .i_h_blank (i_h_blank),
    .i_v_blank (i_v_blank),
    .i_rgb     (i_rgb),
    .o_hcount  (o_hcount),
    .o_vcount  (o_vcount),
    .o_h_sync  (o_h_sync),
    .o_v_sync  (o_v_sync),
    .o_h_blank (o_h_blank),
    .o_v_blank (o_v_blank),
    .o_rgb     (o_rgb),
    .o_hit     (o_hit),
    .o_score   (o_score)
  );

  localparam logic [11:0] GRN = 12'h0f0;
  localparam logic [11:0] WHT = 12'hfff;
  localparam logic [11:0] RED = 12'hf00;
  localparam logic [11:0] BG  = 12'h00f;

  typedef struct {
    int          tag;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic        hit;
    logic [7:0]  score;
  } exp_t;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
    logic [11:0] exp_rgb;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[10];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   sc_exp = 0;
  int   tag    = 0;

  task automatic check(input exp_t e);
    n_vec++;
    if (o_hcount !== e.h || o_vcount !== e.v || o_h_sync !== e.hs || o_v_sync !== e.vs ||
        o_h_blank !== e.hb || o_v_blank !== e.vb || o_rgb !== e.rgb ||
        o_hit !== e.hit || o_score !== e.score) begin
      n_bad++;
      $display("FAIL t%0d pixel: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h hit=%b score=%0d, want h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b rgb=%h hit=%b score=%0d",
               e.tag, o_hcount, o_vcount, o_h_sync, o_v_sync, o_h_blank, o_v_blank, o_rgb, o_hit, o_score,
               e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.rgb, e.hit, e.score);
    end
  endtask

  // Drive one pixel, queue its expected output, and compare the output of the
  // pixel driven one step earlier (two register stages of latency).
  task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb, input logic vb,
                       input logic [11:0] rgb, input logic [11:0] exp_rgb, input logic exp_hit);
    exp_t e;
    i_hcount  = h;
    i_vcount  = v;
    i_h_sync  = h[3];
    i_v_sync  = v[2];
    i_h_blank = hb;
    i_v_blank = vb;
    i_rgb     = rgb;
    e.tag   = tag;
    e.h     = h;
    e.v     = v;
    e.hs    = h[3];
    e.vs    = v[2];
    e.hb    = hb;
    e.vb    = vb;
    e.rgb   = exp_rgb;
    e.hit   = exp_hit;
    e.score = sc_exp[7:0];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      check(e);
    end
  endtask

  task automatic px(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb,
                    input logic [11:0] exp_rgb);
    drive(h, v, 1'b0, 1'b0, rgb, exp_rgb, 1'b0);
  endtask

  task automatic fs(input logic exp_hit);
    drive(11'd0, 11'd0, 1'b0, 1'b0, 12'h0a5, 12'h0a5, exp_hit);
  endtask

  task automatic rst_cycle(input logic [10:0] h, input logic [10:0] v);
    i_rst    = 1'b1;
    i_hcount = h;
    i_vcount = v;
    i_h_sync = 1'b1;
    i_rgb    = 12'h5a5;
    @(posedge clk);
    #1;
    n_vec++;
    if (o_hcount !== '0 || o_vcount !== '0 || o_h_sync !== 1'b0 || o_v_sync !== 1'b0 ||
        o_h_blank !== 1'b0 || o_v_blank !== 1'b0 || o_rgb !== '0 || o_hit !== 1'b0 || o_score !== '0) begin
      n_bad++;
      $display("FAIL reset outputs: got h=%0d v=%0d rgb=%h hit=%b score=%0d, want all zero",
               o_hcount, o_vcount, o_rgb, o_hit, o_score);
    end
  endtask

  task automatic do_hit(input logic [10:0] bx);
    px(bx, 11'd110, RED, RED);
    sc_exp = (sc_exp == 255) ? 255 : sc_exp + 1;
    fs(1'b1);
    repeat (31) fs(1'b0);
  endtask

  initial begin
    tbl[0] = '{11'd20, 11'd100, 1'b0, 1'b0, BG,      GRN};
    tbl[1] = '{11'd19, 11'd100, 1'b0, 1'b0, BG,      BG};
    tbl[2] = '{11'd51, 11'd131, 1'b0, 1'b0, BG,      GRN};
    tbl[3] = '{11'd52, 11'd100, 1'b0, 1'b0, BG,      BG};
    tbl[4] = '{11'd20, 11'd99,  1'b0, 1'b0, BG,      BG};
    tbl[5] = '{11'd20, 11'd132, 1'b0, 1'b0, BG,      BG};
    tbl[6] = '{11'd25, 11'd110, 1'b1, 1'b0, 12'h123, 12'h123};
    tbl[7] = '{11'd25, 11'd110, 1'b0, 1'b1, 12'h123, 12'h123};
    tbl[8] = '{11'd25, 11'd90,  1'b0, 1'b0, RED,     RED};
    tbl[9] = '{11'd25, 11'd110, 1'b0, 1'b1, RED,     RED};

    // 1: power-on reset, a few frames, then reset mid-frame
    tag = 1;
    repeat (3) rst_cycle(11'd400, 11'd300);
    i_rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      fs(1'b0);
      px(11'(2 * k), 11'd100, BG, GRN);
    end
    px(11'd300, 11'd110, BG, BG);
    sb.delete();
    repeat (3) rst_cycle(11'd301, 11'd110);
    i_rst = 1'b0;
    px(11'd0,  11'd100, BG, GRN);
    px(11'd31, 11'd100, BG, GRN);
    px(11'd32, 11'd100, BG, BG);

    // 2: ten frames of motion, no hits
    tag = 2;
    for (int k = 1; k <= 10; k++) begin
      fs(1'b0);
      px(11'(2 * k), 11'd100, BG, GRN);
      px(11'(2 * k + 32), 11'd100, BG, BG);
    end
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].rgb, tbl[i].exp_rgb, 1'b0);
    end

    // 3/5: hit at tx+5 (tx=22), flash frozen, bullet during flash ignored, respawn
    tag = 3;
    fs(1'b0);
    px(11'd27, 11'd110, RED, RED);
    sc_exp = 1;
    fs(1'b1);
    px(11'd700, 11'd500, BG, BG);
    for (int i = 0; i < 30; i++) begin
      px(11'd25, 11'd110, 12'h0ab, WHT);
      px(11'd22, 11'd100, 12'h0ab, WHT);
      px(11'd53, 11'd100, 12'h0ab, WHT);
      px(11'd21, 11'd100, 12'h0ab, 12'h0ab);
      px(11'd54, 11'd100, 12'h0ab, 12'h0ab);
      if (i == 4) px(11'd30, 11'd110, RED, RED);
      fs(1'b0);
    end
    px(11'd25, 11'd110, 12'h0ab, GRN);
    fs(1'b0);
    px(11'd0,  11'd100, BG, GRN);
    px(11'd31, 11'd100, BG, GRN);
    px(11'd32, 11'd100, BG, BG);

    // 4: right-edge bounce
    tag = 4;
    repeat (383) fs(1'b0);
    px(11'd766, 11'd100, BG, GRN);
    px(11'd765, 11'd100, BG, BG);
    fs(1'b0);
    px(11'd767, 11'd100, BG, GRN);
    px(11'd766, 11'd100, BG, BG);
    px(11'd798, 11'd100, BG, GRN);
    px(11'd799, 11'd100, BG, BG);
    fs(1'b0);
    px(11'd765, 11'd100, BG, GRN);
    px(11'd796, 11'd100, BG, GRN);
    px(11'd797, 11'd100, BG, BG);

    // 6: drive the score to 255, then one more hit must still pulse
    tag = 6;
    do_hit(11'd770);
    while (sc_exp < 255) do_hit(11'd5);
    do_hit(11'd5);

    px(11'd700, 11'd500, BG, BG);
    px(11'd701, 11'd500, BG, BG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
